// File: rtl/cond_pkg.sv
// ============================================================================
// Module      : cond_pkg
// Description : Shared types and field indices for the conditional-execution
//               unit (condition encodings, flag and FlagW bit positions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

`default_nettype wire

// File: rtl/cond_unit_cond_check.sv
// ============================================================================
// Module      : cond_check
// Description : Combinational ARM condition-field evaluator: Cond against the
//               {Z,N,C,V} flags, producing the pass bit (NV always fails).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic  w_z, w_n, w_c, w_v;
    cond_e w_cond;

    assign w_z    = Flags[FLAG_Z];
    assign w_n    = Flags[FLAG_N];
    assign w_c    = Flags[FLAG_C];
    assign w_v    = Flags[FLAG_V];
    assign w_cond = cond_e'(Cond);

    always_comb begin
        CondEx = 1'b0;
        case (w_cond)
            EQ:      CondEx = w_z;
            NE:      CondEx = ~w_z;
            CS:      CondEx = w_c;
            CC:      CondEx = ~w_c;
            MI:      CondEx = w_n;
            PL:      CondEx = ~w_n;
            VS:      CondEx = w_v;
            VC:      CondEx = ~w_v;
            HI:      CondEx = w_c & ~w_z;
            LS:      CondEx = ~w_c | w_z;
            GE:      CondEx = ~(w_n ^ w_v);
            LT:      CondEx = w_n ^ w_v;
            GT:      CondEx = ~w_z & ~(w_n ^ w_v);
            LE:      CondEx = w_z | (w_n ^ w_v);
            AL:      CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cond_unit.sv
// ============================================================================
// Module      : cond_unit
// Description : Condition flags, saved-flags copy and write-strobe gating for
//               the single-cycle ARMv4 core. Optional statistics counters are
//               built when COND_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             Save,
    input  logic             Restore,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [3:0]       SavedFlags
`ifdef COND_STATS_EN
    ,
    input  logic             StatClr,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
`endif
);

    logic [3:0] r_flags_q, w_flags_d;
    logic [3:0] r_saved_q, w_saved_d;
    logic       w_cond_ex;

    // Evaluated against the registered flags, so an instruction never sees its own update.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags_q),
        .CondEx (w_cond_ex)
    );

    assign CondEx     = w_cond_ex;
    assign PCSrc      = PCS  & w_cond_ex & ~reset;
    assign RegWrite   = RegW & w_cond_ex & ~NoWrite & ~reset;
    assign MemWrite   = MemW & w_cond_ex & ~reset;
    assign Flags      = r_flags_q;
    assign SavedFlags = r_saved_q;

    always_comb begin
        w_flags_d = r_flags_q;
        if (w_cond_ex && FlagW[FW_NZ]) begin
            w_flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            w_flags_d[FLAG_N] = ALUFlags[FLAG_N];
        end
        if (w_cond_ex && FlagW[FW_CV]) begin
            w_flags_d[FLAG_C] = ALUFlags[FLAG_C];
            w_flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        // Exception return wins over any flag-setting instruction in the same cycle.
        if (Restore) begin
            w_flags_d = r_saved_q;
        end
        w_saved_d = Save ? r_flags_q : r_saved_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags_q <= 4'b0000;
            r_saved_q <= 4'b0000;
        end else begin
            r_flags_q <= w_flags_d;
            r_saved_q <= w_saved_d;
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_exec_q, w_exec_d;
    logic [CNT_W-1:0] r_skip_q, w_skip_d;

    always_comb begin
        w_exec_d = r_exec_q;
        w_skip_d = r_skip_q;
        if (StatClr) begin
            w_exec_d = '0;
            w_skip_d = '0;
        end else if (w_cond_ex) begin
            if (r_exec_q != c_cnt_max) w_exec_d = r_exec_q + c_cnt_one;
        end else begin
            if (r_skip_q != c_cnt_max) w_skip_d = r_skip_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_q <= '0;
            r_skip_q <= '0;
        end else begin
            r_exec_q <= w_exec_d;
            r_skip_q <= w_skip_d;
        end
    end

    assign ExecCount = r_exec_q;
    assign SkipCount = r_skip_q;
`else
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule

`default_nettype wire

// File: doc/cond_unit.md
# cond_unit

Conditional-execution and flag-state unit for the single-cycle ARMv4 core. It holds the architectural condition flags and updates them from the ALU under per-field write enables. It evaluates each instruction's condition field against the held flags and gates the decoder's write strobes (PC, register file, memory). It also keeps a saved-flags copy for exception entry and return.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters (only used when COND_STATS_EN is defined)

Ports:
- clk  in  1  core clock, rising-edge
- reset  in  1  synchronous, active-high
- Cond  in  4  instruction bits 31:28
- ALUFlags  in  4  {Z,N,C,V} from the ALU, bit 3 = Z, bit 0 = V
- FlagW  in  2  bit 1 = update Z,N; bit 0 = update C,V
- PCS, RegW, MemW  in  1 each  ungated decoder strobes
- NoWrite  in  1  compare-type instruction; suppresses RegWrite
- Save  in  1  exception entry: copy live flags to saved flags
- Restore  in  1  exception return: copy saved flags to live flags
- PCSrc, RegWrite, MemWrite  out  1 each  gated strobes
- CondEx  out  1  condition passed for the current instruction
- Flags  out  4  live flags {Z,N,C,V}
- SavedFlags  out  4  saved flags {Z,N,C,V}
- StatClr  in  1  clears the counters (COND_STATS_EN only)
- ExecCount, SkipCount  out  CNT_W  executed and skipped instruction counts (COND_STATS_EN only)

## Operation
- CondEx is combinational from Cond and the registered Flags, using the pre-update value of the current cycle.
- Condition codes: 0000 EQ through 1110 AL, with the standard ARM semantics.
- 1111 is reserved and gives CondEx = 0, never X.
- PCSrc = PCS & CondEx.
- RegWrite = RegW & CondEx & ~NoWrite.
- MemWrite = MemW & CondEx.
- All three gated strobes are forced to 0 while reset is high.
- Live flag update at the rising edge, only when CondEx = 1:
  - FlagW[1] loads Z,N from ALUFlags.
  - FlagW[0] loads C,V from ALUFlags.
  - Each field is independent; the unselected field holds.
- Save loads SavedFlags from the live Flags as they were before this edge's update.
- Restore loads Flags from SavedFlags and overrides any FlagW update in the same cycle.
- Save and Restore in the same cycle swap the two registers.
- Save and Restore act regardless of CondEx; the exception sequencer drives them, not the instruction.
- Priority on Flags: reset > Restore > FlagW. On SavedFlags: reset > Save.

## Timing
- Reset values: Flags = 0000, SavedFlags = 0000, counters = 0. Gated strobes read 0 during reset.
- After reset releases, CondEx is evaluated with all flags clear, so EQ fails and NE passes.
- Flag writes take effect one cycle later. An instruction sees flags written by its predecessor, never its own.
- Combinational path from Cond, PCS, RegW, MemW and NoWrite to the outputs; no added latency.
- Reset asserted mid-sequence, including between Save and Restore, discards the saved state.

## Configuration
- COND_STATS_EN defined:
  - ExecCount increments every non-reset cycle with CondEx = 1.
  - SkipCount increments every non-reset cycle with CondEx = 0.
  - Both counters saturate at all-ones, with no wrap.
  - StatClr clears both counters and has priority over increment.
- COND_STATS_EN undefined: the StatClr, ExecCount and SkipCount ports and the counter logic are absent; all other behaviour is identical.

## Structure
- Package cond_pkg:
  - cond_e enum of the 16 condition encodings (EQ…AL, NV = 1111).
  - Flag index localparams FLAG_Z = 3, FLAG_N = 2, FLAG_C = 1, FLAG_V = 0.
  - FlagW field localparams FW_NZ = 1, FW_CV = 0.
- One sub-module, cond_check: purely combinational, taking Cond and the 4-bit flags and producing the pass bit.
- The flag registers, saved-flags register, gating and counters live in cond_unit.

## Test plan
- Reset check: hold reset 2 cycles with PCS = RegW = MemW = 1 and Cond = 1110.
  - During reset: all gated strobes are 0.
  - After release: Flags = 0000 and RegWrite = 1.
- Split flag write: ALUFlags = 1111, FlagW = 10, Cond = AL. Next cycle Flags = 1100; then FlagW = 01 gives Flags = 1111.
- Suppressed update: Flags = 1000 (Z set), Cond = NE, FlagW = 11, ALUFlags = 0000. Then:
  - CondEx = 0 and all strobes are 0.
  - Flags remain 1000.
- Compare then branch: CMP with result Z=1 (FlagW = 11, NoWrite = 1) gives RegWrite = 0. Next cycle, BEQ with PCS = 1 gives PCSrc = 1.
- Save and Restore:
  - Flags = 0110; Save together with FlagW = 11, ALUFlags = 1001.
  - Expect SavedFlags = 0110 and Flags = 1001.
  - Restore together with FlagW = 11 gives Flags = 0110.
  - Save together with Restore swaps the two registers.
- Statistics (COND_STATS_EN defined):
  - 5 cycles of AL and 3 cycles of NV give ExecCount = 5 and SkipCount = 3.
  - StatClr together with CondEx = 1 gives 0/0 next cycle.
  - Preloading CNT_W = 4 to 15 and then passing a condition keeps the count at 15.
